// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: SPI mode-0 slave (MSB first) acting as register-bus master
// for the PWM register file. All SPI pins are oversampled in clk_i.
// Frame: one command byte {rw, addr[6:0]} followed by one or more data bytes.
// Optional build macro ADDR_AUTOINC_EN: when defined, the register address
// advances by one after every completed data byte (burst walks registers);
// when undefined, the address stays at the command address for the frame.
module spi_reg_bridge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       nrst_i,
  input  logic       spi_sck_i,
  input  logic       spi_cs_n_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  output logic [7:0] b_addr_o,
  output logic [7:0] b_data_o,
  output logic       b_write_o,
  input  logic [7:0] b_data_i
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic       sck_prev_q, sck_prev_d;
  logic [1:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic       rw_q, rw_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       write_q, write_d;
  logic       load_q, load_d;
`ifdef ADDR_AUTOINC_EN
  logic       inc_q, inc_d;
`endif

  logic       sck_s, cs_s, mosi_s;
  logic       rise_p, fall_p, byte_done;
  logic [7:0] rx_byte;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign rise_p  = sck_s & ~sck_prev_q;
  assign fall_p  = ~sck_s & sck_prev_q;
  // Byte as it will look once the current MOSI bit is shifted in
  assign rx_byte = {rx_q[6:0], mosi_s};
  // A byte completes on the rising edge that wraps the counter; a
  // simultaneous deselect suppresses it so no write can slip out
  assign byte_done = rise_p && (bit_cnt_q == 3'd7) && !cs_s && (state_q != ST_IDLE);

  assign spi_miso_o = ~cs_s & tx_q[7];
  assign b_addr_o   = addr_q;
  assign b_data_o   = wdata_q;
  assign b_write_o  = write_q;

  // Pin synchronisers and SCK edge history
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck_i};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n_i};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
    sck_prev_d  = sck_s;
  end

  // Frame FSM, shift registers and register-bus sequencing
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = 1'b0;
    load_d    = 1'b0;
`ifdef ADDR_AUTOINC_EN
    inc_d     = 1'b0;
`endif

    case (state_q)
      ST_CMD, ST_DATA: begin
        if (cs_s) begin
          // Deselect: drop any partial byte and return to idle
          state_d   = ST_IDLE;
          bit_cnt_d = 3'd0;
        end else begin
          if (rise_p) begin
            rx_d      = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
          if (byte_done) begin
            if (state_q == ST_CMD) begin
              rw_d    = rx_byte[7];
              addr_d  = {1'b0, rx_byte[6:0]};
              state_d = ST_DATA;
              load_d  = ~rx_byte[7];
            end else if (rw_q) begin
              wdata_d = rx_byte;
              write_d = 1'b1;
`ifdef ADDR_AUTOINC_EN
              inc_d   = 1'b1;
`endif
            end else begin
`ifdef ADDR_AUTOINC_EN
              addr_d  = addr_q + 8'd1;
`endif
              load_d  = 1'b1;
            end
          end
          // First falling edge of a byte keeps bit 7 on MISO
          if (fall_p && (state_q == ST_DATA) && (bit_cnt_q != 3'd0)) begin
            tx_d = {tx_q[6:0], 1'b0};
          end
          // Read data is captured one cycle after the address settles
          if (load_q) begin
            tx_d = b_data_i;
          end
        end
      end
      default: begin
        tx_d      = 8'h00;
        rx_d      = 8'h00;
        rw_d      = 1'b0;
        bit_cnt_d = 3'd0;
        if (!cs_s) begin
          state_d = ST_CMD;
        end
      end
    endcase

`ifdef ADDR_AUTOINC_EN
    // Write bursts advance the address the cycle after each strobe
    if (inc_q) begin
      addr_d = addr_q + 8'd1;
    end
`endif
  end

  // State registers
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      rw_q        <= 1'b0;
      addr_q      <= 8'h00;
      wdata_q     <= 8'h00;
      write_q     <= 1'b0;
      load_q      <= 1'b0;
`ifdef ADDR_AUTOINC_EN
      inc_q       <= 1'b0;
`endif
    end else begin
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      load_q      <= load_d;
`ifdef ADDR_AUTOINC_EN
      inc_q       <= inc_d;
`endif
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Testbench for spi_reg_bridge: directed SPI frames, scoreboard queues for
// register writes and MISO bytes, separate monitors that pop and compare.
module tb_spi_reg_bridge;
  localparam int SYNC_STAGES = 2;
  localparam int HALF = 8;

  logic       clk_i = 1'b0;
  logic       nrst_i = 1'b0;
  logic       sck = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic [7:0] b_addr;
  logic [7:0] b_data;
  logic       b_write;
  logic [7:0] rdata;

  logic [7:0] mem [256];
  assign rdata = mem[b_addr];

  spi_reg_bridge #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk_i      (clk_i),
    .nrst_i     (nrst_i),
    .spi_sck_i  (sck),
    .spi_cs_n_i (cs_n),
    .spi_mosi_i (mosi),
    .spi_miso_o (miso),
    .b_addr_o   (b_addr),
    .b_data_o   (b_data),
    .b_write_o  (b_write),
    .b_data_i   (rdata)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        wr_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] rd_obs;
  event       rd_ev;
  int         n_cmp = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         last_rise = 0;

  task automatic check8(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h want %02h", nm, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // Write monitor: every strobe must match the head of the write queue
  initial begin
    logic prev_wr;
    wr_t  e;
    prev_wr = 1'b0;
    forever begin
      @(negedge clk_i);
      if (b_write === 1'b1) begin
        if (prev_wr) begin
          n_cmp++;
          n_fail++;
          $display("FAIL wr_consecutive: got strobe on back-to-back cycles, want single");
        end
        if (wr_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL wr_unexpected: got strobe addr %02h data %02h, want none", b_addr, b_data);
        end else begin
          e = wr_q.pop_front();
          $display("wr  addr=%02h data=%02h (exp %02h/%02h) lat=%0d", b_addr, b_data, e.a, e.d, cyc - last_rise);
          check8("wr_addr", b_addr, e.a);
          check8("wr_data", b_data, e.d);
          n_cmp++;
          if (cyc - last_rise > SYNC_STAGES + 3) begin
            n_fail++;
            $display("FAIL wr_latency: got %0d cycles, want <= %0d", cyc - last_rise, SYNC_STAGES + 3);
          end
        end
      end
      prev_wr = (b_write === 1'b1);
    end
  end

  // Read monitor: every host-received byte is compared to the MISO queue
  initial forever begin
    @(rd_ev);
    if (rd_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL miso_unexpected: got byte %02h, want none", rd_obs);
    end else begin
      check8("miso_byte", rd_obs, rd_q.pop_front());
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic spi_bits(input logic [7:0] v, input int n, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = v[7-i];
      repeat (HALF) @(negedge clk_i);
      r = {r[6:0], miso};
      sck = 1'b1;
      last_rise = cyc;
      repeat (HALF) @(negedge clk_i);
      sck = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] v, input logic [7:0] exp_miso);
    logic [7:0] r;
    rd_q.push_back(exp_miso);
    spi_bits(v, 8, r);
    $display("xfer mosi=%02h miso=%02h (exp %02h)", v, r, exp_miso);
    rd_obs = r;
    ->rd_ev;
  endtask

  task automatic cs_start();
    @(negedge clk_i);
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk_i);
  endtask

  task automatic cs_end();
    repeat (HALF) @(negedge clk_i);
    cs_n = 1'b1;
    repeat (2 * HALF) @(negedge clk_i);
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    wr_q.push_back(e);
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] a;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'(i) ^ 8'hA5;
    end
    mem[0] = 8'h3C;

    // Reset state
    repeat (3) @(negedge clk_i);
    check8("rst_miso", {7'd0, miso}, 8'h00);
    check8("rst_addr", b_addr, 8'h00);
    check8("rst_data", b_data, 8'h00);
    check8("rst_write", {7'd0, b_write}, 8'h00);
    nrst_i = 1'b1;
    repeat (4) @(negedge clk_i);

    // Single write: 82 A5 -> (02, A5)
    push_wr(8'h02, 8'hA5);
    cs_start();
    xfer(8'h82, 8'h00);
    xfer(8'hA5, 8'h00);
    cs_end();

    // Single read of address 00
    cs_start();
    xfer(8'h00, 8'h00);
    xfer(8'h00, 8'h3C);
    cs_end();

    // Burst write 81 01 2C
    push_wr(8'h01, 8'h01);
`ifdef ADDR_AUTOINC_EN
    push_wr(8'h02, 8'h2C);
`else
    push_wr(8'h01, 8'h2C);
`endif
    cs_start();
    xfer(8'h81, 8'h00);
    xfer(8'h01, 8'h00);
    xfer(8'h2C, 8'h00);
    cs_end();

    // Burst read of three bytes starting at address 05
    cs_start();
    xfer(8'h05, 8'h00);
    for (int k = 0; k < 3; k++) begin
`ifdef ADDR_AUTOINC_EN
      a = 8'h05 + 8'(k);
`else
      a = 8'h05;
`endif
      xfer(8'h00, mem[a]);
    end
    cs_end();

    // Abort after 5 data bits: no strobe, then a clean frame
    cs_start();
    xfer(8'h82, 8'h00);
    spi_bits(8'hFF, 5, r);
    cs_end();
    push_wr(8'h02, 8'h11);
    cs_start();
    xfer(8'h82, 8'h00);
    xfer(8'h11, 8'h00);
    cs_end();

    // Reset after 12 SCK rises: outputs clear at once, frame abandoned
    cs_start();
    xfer(8'h83, 8'h00);
    spi_bits(8'hF0, 4, r);
    repeat (2) @(negedge clk_i);
    nrst_i = 1'b0;
    #1;
    check8("midrst_miso", {7'd0, miso}, 8'h00);
    check8("midrst_addr", b_addr, 8'h00);
    check8("midrst_data", b_data, 8'h00);
    check8("midrst_write", {7'd0, b_write}, 8'h00);
    cs_n = 1'b1;
    repeat (4) @(negedge clk_i);
    nrst_i = 1'b1;
    repeat (8) @(negedge clk_i);
    push_wr(8'h04, 8'h5A);
    cs_start();
    xfer(8'h84, 8'h00);
    xfer(8'h5A, 8'h00);
    cs_end();

`ifdef ADDR_AUTOINC_EN
    // Read burst from 7F across FF -> 00
    cs_start();
    xfer(8'h7F, 8'h00);
    for (int k = 0; k < 130; k++) begin
      a = 8'h7F + 8'(k);
      xfer(8'h00, mem[a]);
    end
    cs_end();
`endif

    repeat (20) @(negedge clk_i);
    n_cmp++;
    if (wr_q.size() != 0) begin
      n_fail++;
      $display("FAIL wr_missing: got %0d strobes outstanding, want 0", wr_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
- SPI slave (mode 0, MSB first) that acts as the register-bus master for the PWM register file.
- Drives b_addr/b_data/b_write into the PWM block and returns read data from its b_data_o.
- Sits between the external host pins and the PWM core. Everything runs in the clk_i domain: SPI pins are oversampled, not used as clocks.

Parameters:
SYNC_STAGES, 2, number of flip-flops in each pin synchroniser (sck, cs_n, mosi); legal range 2..4

Ports:
clk_i  input  1  system clock; must be >= 8x SCK frequency
nrst_i  input  1  asynchronous active-low reset
spi_sck_i  input  1  SPI clock from host, idle low
spi_cs_n_i  input  1  SPI chip select, active low
spi_mosi_i  input  1  host-to-slave data
spi_miso_o  output  1  slave-to-host data, driven low when not selected
b_addr_o  output  8  register address to PWM block
b_data_o  output  8  write data to PWM block
b_write_o  output  1  one-cycle write strobe
b_data_i  input  8  read data from PWM block, combinational on b_addr_o

Behaviour:
- Reset (async, nrst_i low):
  - Outputs: spi_miso_o=0, b_addr_o=8'h00, b_data_o=8'h00, b_write_o=0.
  - Internal: state=IDLE, bit counter=0, shift registers=0.
  - Reset mid-frame abandons the frame; no write is issued.
- Synchronisers: sck, cs_n and mosi each pass through SYNC_STAGES flops.
  - Edge detect on synced sck against its previous value gives rise_p and fall_p, one cycle each.
  - All timing below is relative to rise_p/fall_p.
- States: IDLE, CMD, DATA.
  - IDLE -> CMD when synced cs_n=0. Bit counter cleared.
  - Any state -> IDLE one cycle after synced cs_n=1. A partial byte is discarded; no write.
- Receive:
  - On rise_p, shift synced mosi into rx[0] (MSB first) and increment the 3-bit bit counter.
  - A byte completes on the rise_p that wraps the counter 7->0.
- CMD byte complete (cycle t):
  - t+1: latch rw=rx[7] (1=write, 0=read) and b_addr_o={1'b0, rx[6:0]}; go to DATA.
  - t+2, if read: load tx from b_data_i.
- DATA byte complete, write (cycle t):
  - t+1: b_data_o=rx byte and b_write_o=1 for exactly one cycle. b_addr_o is stable during the strobe.
- DATA byte complete, read (cycle t): MOSI bits are ignored, no write.
  - t+1: address update if ADDR_AUTOINC_EN (see Optional Feature).
  - t+2: reload tx from b_data_i.
- MISO:
  - spi_miso_o = tx[7] while synced cs_n=0, else 0.
  - On fall_p in DATA with bit counter != 0, tx shifts left, filling 0.
  - The first falling edge of each byte (counter==0) does not shift, so bit 7 is valid before the first rising edge.
  - For write frames, tx=0 and MISO reads 0.
- Bursts: after the first DATA byte, further bytes keep the frame in DATA.
  - Each further byte is another write (strobe per byte) or another read.
- Address arithmetic: 8-bit, modulo 256 (8'hFF -> 8'h00).
- Simultaneous cs_n rise and byte completion in the same cycle: cs_n wins, no write.
- b_write_o never asserts outside DATA and never on consecutive cycles.

Optional Feature:
- Macro: ADDR_AUTOINC_EN.
- Defined: after each completed DATA byte, b_addr_o increments by 1 in the cycle after the strobe (write) or at t+1 (read). Burst reads/writes therefore walk consecutive registers.
- Not defined: b_addr_o holds the CMD address for the whole frame. Burst writes re-write the same register; burst reads return the same register repeatedly.

Test Plan:
- Write: CS low, bytes 8'h82, 8'hA5, CS high -> one b_write_o pulse with b_addr_o=8'h02, b_data_o=8'hA5, within SYNC_STAGES+3 clk_i cycles of the 16th SCK rise; no other strobe.
- Read: preset b_data_i=8'h3C for addr 8'h00; send 8'h00 then 8'h00 -> host samples 8'h3C on MISO; b_write_o stays 0.
- Burst write, ADDR_AUTOINC_EN defined: 8'h81, 8'h01, 8'h2C -> strobes (addr 01, data 01) then (addr 02, data 2C).
  - Same stimulus without the macro -> both strobes at addr 01.
- Abort: 8'h82 followed by 5 data bits, then CS high -> no strobe, state returns to IDLE; the next full frame 8'h82, 8'h11 writes 8'h11 to 02.
- Reset mid-frame: assert nrst_i low after 12 SCK rises -> all outputs 0 immediately; after release and CS toggle, a clean frame works.
- Wrap, ADDR_AUTOINC_EN defined: read burst starting at 8'h7F of 130 data bytes -> address sequence 7F, 80, …, FF, 00.
